// File: rtl/counter_checker_pkg.sv
// counter_checker_pkg: shared FSM states, control record and uio pin map for the counter checker.
package counter_checker_pkg;
    typedef enum logic [1:0] {IDLE, SEED, TRACK, LOCKED} state_t;
    typedef struct packed {
        logic dir;
        logic en;
    } ctl_t;
    localparam int DIR_BIT = 0;
    localparam int EN_BIT = 1;
    localparam int ARM_BIT = 2;
    localparam int CLR_BIT = 3;
    localparam int SEL_BIT = 4;
    localparam logic [7:0] UIO_OE_MASK = 8'hE0;
endpackage

// File: rtl/counter_checker_predict.sv
// counter_checker_predict: next count expected from a sample and the controls seen with it.
module counter_checker_predict
    import counter_checker_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] cnt,
    input  ctl_t             ctl,
    output logic [WIDTH-1:0] pred
);
    always_comb pred = !ctl.en ? cnt : ctl.dir ? cnt + WIDTH'(1) : cnt - WIDTH'(1);
endmodule

// File: rtl/tt_um_ulriktj_counter_checker.sv
// tt_um_ulriktj_counter_checker: observes an external up/down counter and flags every broken step.
// Define CHECKER_LAST_BAD_EN to keep the last bad sample, selectable onto uo_out via out_sel.
module tt_um_ulriktj_counter_checker
    import counter_checker_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int ERR_W = 8,
    parameter int LOCK_CNT = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);
    logic [WIDTH-1:0] cnt_q, cnt_qq, pred;
    ctl_t ctl_q, ctl_qq;
    state_t state, state_d;
    logic [3:0] run, run_d;
    logic [ERR_W-1:0] err_cnt;
    logic err_pulse, sticky_fail, match, err, arm, clear;

    assign arm = uio_in[ARM_BIT];
    assign clear = uio_in[CLR_BIT];
    assign match = cnt_q == pred;
    assign err = (state == TRACK || state == LOCKED) && !match;

    counter_checker_predict #(.WIDTH(WIDTH)) u_predict (
        .cnt(cnt_qq),
        .ctl(ctl_qq),
        .pred(pred)
    );

    always_comb begin
        state_d = state;
        run_d = run;
        case (state)
            IDLE: state_d = arm ? SEED : IDLE;
            SEED: begin
                state_d = TRACK;
                run_d = '0;
            end
            TRACK: begin
                state_d = (match && run == 4'(LOCK_CNT - 1)) ? LOCKED : TRACK;
                run_d = (match && run != 4'(LOCK_CNT - 1)) ? run + 4'd1 : '0;
            end
            LOCKED: state_d = match ? LOCKED : TRACK;
        endcase
        if (!arm) state_d = IDLE;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            run <= '0;
            cnt_q <= '0;
            cnt_qq <= '0;
            ctl_q <= '0;
            ctl_qq <= '0;
            err_cnt <= '0;
            err_pulse <= 1'b0;
            sticky_fail <= 1'b0;
        end else if (ena) begin
            state <= state_d;
            run <= run_d;
            cnt_q <= ui_in[WIDTH-1:0];
            cnt_qq <= cnt_q;
            ctl_q <= {uio_in[DIR_BIT], uio_in[EN_BIT]};
            ctl_qq <= ctl_q;
            err_cnt <= clear ? '0 : (err && !(&err_cnt)) ? err_cnt + ERR_W'(1) : err_cnt;
            err_pulse <= err;
            sticky_fail <= !clear && (sticky_fail || err);
        end
    end

`ifdef CHECKER_LAST_BAD_EN
    logic [WIDTH-1:0] last_bad;
    logic unused;

    always_ff @(posedge clk) begin
        if (!rst_n) last_bad <= '0;
        else if (ena) last_bad <= clear ? '0 : err ? cnt_q : last_bad;
    end

    assign uo_out = uio_in[SEL_BIT] ? 8'(last_bad) : 8'(err_cnt);
    assign unused = &{1'b0, uio_in[7:5]};
`else
    logic unused;

    assign uo_out = 8'(err_cnt);
    assign unused = &{1'b0, uio_in[7:4]};
`endif

    assign uio_out = {sticky_fail, err_pulse, state == LOCKED, 5'b0};
    assign uio_oe = UIO_OE_MASK;
endmodule

// File: tb/tb_tt_um_ulriktj_counter_checker.sv
// tb_tt_um_ulriktj_counter_checker: directed vector table plus hand sequences for saturation, clear, freeze, out_sel.
module tb_tt_um_ulriktj_counter_checker;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic ena = 1'b0;
    logic [7:0] ui_in = 8'h00;
    logic [7:0] uio_in = 8'h00;
    logic [7:0] uo_out, uio_out, uio_oe;
    int tests = 0;
    int fails = 0;

    typedef struct {
        logic       rst_n;
        logic [7:0] ui;
        logic [7:0] uio;
        logic [7:0] uo;
        logic [7:0] uo_io;
    } vec_t;
    vec_t vecs[$];

    tt_um_ulriktj_counter_checker dut (
        .clk(clk),
        .rst_n(rst_n),
        .ena(ena),
        .ui_in(ui_in),
        .uio_in(uio_in),
        .uo_out(uo_out),
        .uio_out(uio_out),
        .uio_oe(uio_oe)
    );

    always #5 clk = ~clk;

    task automatic add(input logic r, input logic [7:0] ui, input logic [7:0] uio,
                       input logic [7:0] uo, input logic [7:0] uo_io);
        vecs.push_back('{r, ui, uio, uo, uo_io});
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    task automatic outs(input string name, input logic [7:0] uo, input logic [7:0] uo_io);
        chk({name, " uo_out"}, uo_out, uo);
        chk({name, " uio_out"}, uio_out, uo_io);
        chk({name, " uio_oe"}, uio_oe, 8'hE0);
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            rst_n = 1'b0;
            ui_in = 8'($urandom);
            uio_in = 8'($urandom);
            ena = 1'($urandom);
            step;
            outs($sformatf("reset%0d", i), 8'h00, 8'h00);
        end

        // clean up-count across the FF->00 wrap
        add(1, 8'hFA, 8'h03, 8'h00, 8'h00);
        add(1, 8'hFB, 8'h07, 8'h00, 8'h00);
        add(1, 8'hFC, 8'h07, 8'h00, 8'h00);
        add(1, 8'hFD, 8'h07, 8'h00, 8'h00);
        add(1, 8'hFE, 8'h07, 8'h00, 8'h00);
        add(1, 8'hFF, 8'h07, 8'h00, 8'h00);
        add(1, 8'h00, 8'h07, 8'h00, 8'h20);
        add(1, 8'h01, 8'h07, 8'h00, 8'h20);
        add(1, 8'h02, 8'h07, 8'h00, 8'h20);
        add(1, 8'h03, 8'h07, 8'h00, 8'h20);
        add(1, 8'h04, 8'h07, 8'h00, 8'h20);
        add(1, 8'h05, 8'h07, 8'h00, 8'h20);
        // reset while locked, then down-count with a single glitch
        add(0, 8'h55, 8'h07, 8'h00, 8'h00);
        add(1, 8'h26, 8'h02, 8'h00, 8'h00);
        add(1, 8'h25, 8'h06, 8'h00, 8'h00);
        add(1, 8'h24, 8'h06, 8'h00, 8'h00);
        add(1, 8'h23, 8'h06, 8'h00, 8'h00);
        add(1, 8'h22, 8'h06, 8'h00, 8'h00);
        add(1, 8'h21, 8'h06, 8'h00, 8'h00);
        add(1, 8'h20, 8'h06, 8'h00, 8'h20);
        add(1, 8'h1F, 8'h06, 8'h00, 8'h20);
        add(1, 8'h55, 8'h06, 8'h00, 8'h20);
        add(1, 8'h1D, 8'h06, 8'h01, 8'hC0);
        add(1, 8'h1C, 8'h06, 8'h02, 8'hC0);
        add(1, 8'h1B, 8'h06, 8'h02, 8'h80);
        add(1, 8'h1A, 8'h06, 8'h02, 8'h80);
        add(1, 8'h19, 8'h06, 8'h02, 8'h80);
        add(1, 8'h18, 8'h06, 8'h02, 8'hA0);
        // step enable low: held value matches, a bump costs one error
        add(0, 8'h00, 8'h00, 8'h00, 8'h00);
        add(1, 8'h42, 8'h04, 8'h00, 8'h00);
        add(1, 8'h42, 8'h04, 8'h00, 8'h00);
        add(1, 8'h42, 8'h04, 8'h00, 8'h00);
        add(1, 8'h43, 8'h04, 8'h00, 8'h00);
        add(1, 8'h43, 8'h04, 8'h01, 8'hC0);
        add(1, 8'h43, 8'h04, 8'h01, 8'h80);
        add(1, 8'h43, 8'h04, 8'h01, 8'h80);

        ena = 1'b1;
        foreach (vecs[i]) begin
            rst_n = vecs[i].rst_n;
            ui_in = vecs[i].ui;
            uio_in = vecs[i].uio;
            step;
            outs($sformatf("vec%0d", i), vecs[i].uo, vecs[i].uo_io);
        end

        // alternating samples with step enable low mismatch every cycle once tracking
        rst_n = 1'b0;
        step;
        rst_n = 1'b1;
        uio_in = 8'h04;
        for (int n = 1; n <= 300; n++) begin
            ui_in = n[0] ? 8'h00 : 8'hFF;
            step;
            if (n == 256) outs("sat-1", 8'hFE, 8'hC0);
        end
        outs("sat", 8'hFF, 8'hC0);
        uio_in = 8'h0C;
        ui_in = 8'h00;
        step;
        outs("clear+err", 8'h00, 8'h40);
        uio_in = 8'h04;
        ui_in = 8'hFF;
        step;
        outs("after clear", 8'h01, 8'hC0);
        ena = 1'b0;
        for (int i = 0; i < 10; i++) begin
            ui_in = 8'($urandom);
            uio_in = 8'($urandom) & 8'h0F;
            step;
            outs($sformatf("freeze%0d", i), 8'h01, 8'hC0);
        end
        ena = 1'b1;
        uio_in = 8'h04;
        ui_in = 8'h00;
        step;
        outs("unfreeze", 8'h02, 8'hC0);

        // bad sample capture and output select
        rst_n = 1'b0;
        step;
        rst_n = 1'b1;
        uio_in = 8'h04;
        ui_in = 8'h10;
        step;
        step;
        ui_in = 8'h9A;
        step;
        step;
        outs("bad sample", 8'h01, 8'hC0);
        uio_in = 8'h14;
        #1;
`ifdef CHECKER_LAST_BAD_EN
        chk("out_sel=1", uo_out, 8'h9A);
`else
        chk("out_sel=1", uo_out, 8'h01);
`endif
        uio_in = 8'h04;
        #1;
        chk("out_sel=0", uo_out, 8'h01);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
